// File: rtl/toll_gate_top.sv
// Toll lane controller: vehicle speed timing, restoring divider, UART speed report and barrier control.
// Build option: define TOLL_OVERSPEED_EN to append an overspeed flag frame and suppress E-pass opening for speeders.
module toll_gate_top #(
  parameter int SYS_FREQ    = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int WIDTH_MS    = 16,
  parameter int WIDTH_SPEED = 14
`ifdef TOLL_OVERSPEED_EN
  , parameter int SPEED_LIMIT = 600
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor1,
  input  logic       sensor2,
  input  logic       sensor3,
  input  logic [1:0] valid_Epass,
  input  logic       enable,
  output logic       barrier,
  output logic       serial_data_out
);

  localparam int TICK_CYC = SYS_FREQ / 1000;
  localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

  localparam int BIT_CYC = SYS_FREQ / BAUD;
  localparam int BAUD_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);

  // 144000 = 4 m * 3.6 * 10 * 1000; the result is in 0.1 km/h for a time in ms.
  localparam int DIV_W = 18;
  localparam logic [DIV_W-1:0] DIVIDEND_V  = DIV_W'(144000);
  localparam logic [DIV_W-1:0] SPEED_MAX_Q = DIV_W'((1 << WIDTH_SPEED) - 1);
  localparam logic [WIDTH_SPEED-1:0] SPEED_MAX = {WIDTH_SPEED{1'b1}};
  localparam logic [4:0] DIV_STEPS = 5'(DIV_W);

`ifdef TOLL_OVERSPEED_EN
  localparam logic [1:0] LAST_FRAME = 2'd2;
  localparam logic [WIDTH_SPEED-1:0] SPEED_LIMIT_V = WIDTH_SPEED'(SPEED_LIMIT);
`else
  localparam logic [1:0] LAST_FRAME = 2'd1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    TIMING,
    DIVIDE,
    SEND,
    WAIT_EXIT
  } state_t;

  state_t state_q;

  logic [5:0] syncA_q, syncB_q;
  logic [2:0] prev_q;
  logic [TICK_W-1:0] tickCnt_q;
  logic [WIDTH_MS-1:0] ms_q;
  logic [WIDTH_MS-1:0] rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [4:0] divCnt_q;
  logic [WIDTH_SPEED-1:0] speed_q;
  logic [1:0] frameIdx_q;
  logic [3:0] bitIdx_q;
  logic [BAUD_W-1:0] baudCnt_q;
  logic txLine_q;
  logic barrier_q, barrier_d;

  logic s1, s2, s3, en;
  logic [1:0] pass;
  logic rise1, rise2, fall3, tick;
  logic [WIDTH_MS:0] trial;
  logic fits;
  logic [WIDTH_MS-1:0] remSub, rem_d;
  logic [DIV_W-1:0] quo_d;
  logic [15:0] speed16;
  logic [7:0] frameByte;
  logic epassSet;

  // Bit order in the synchronizer: {enable, valid_Epass, sensor3, sensor2, sensor1}.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      syncA_q <= '0;
      syncB_q <= '0;
      prev_q  <= '0;
    end else begin
      syncA_q <= {enable, valid_Epass, sensor3, sensor2, sensor1};
      syncB_q <= syncA_q;
      prev_q  <= syncB_q[2:0];
    end
  end

  assign s1    = syncB_q[0];
  assign s2    = syncB_q[1];
  assign s3    = syncB_q[2];
  assign pass  = syncB_q[4:3];
  assign en    = syncB_q[5];
  assign rise1 = s1 & ~prev_q[0];
  assign rise2 = s2 & ~prev_q[1];
  assign fall3 = ~s3 & prev_q[2];

  always_ff @(posedge clk) begin
    if (reset_n || tickCnt_q == TICK_LAST) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_q + TICK_W'(1);
    end
  end

  assign tick = (tickCnt_q == TICK_LAST);

  // One restoring step: shift the next dividend bit into the remainder and subtract if it fits.
  assign trial  = {rem_q, quo_q[DIV_W-1]};
  assign fits   = (trial >= {1'b0, ms_q});
  assign remSub = trial[WIDTH_MS-1:0] - ms_q;
  assign rem_d  = fits ? remSub : trial[WIDTH_MS-1:0];
  assign quo_d  = {quo_q[DIV_W-2:0], fits};

  assign speed16 = 16'(speed_q);

`ifdef TOLL_OVERSPEED_EN
  logic overspeed;
  assign overspeed = (speed_q > SPEED_LIMIT_V);
`endif

  always_comb begin
    frameByte = 8'h00;
    case (frameIdx_q)
      2'd0:    frameByte = speed16[15:8];
      2'd1:    frameByte = speed16[7:0];
`ifdef TOLL_OVERSPEED_EN
      2'd2:    frameByte = {7'd0, overspeed};
`endif
      default: frameByte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q    <= IDLE;
      ms_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divCnt_q   <= '0;
      speed_q    <= '0;
      frameIdx_q <= '0;
      bitIdx_q   <= '0;
      baudCnt_q  <= '0;
      txLine_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise1) begin
            ms_q    <= '0;
            state_q <= TIMING;
          end
        end

        TIMING: begin
          if (tick && ms_q != '1) begin
            ms_q <= ms_q + WIDTH_MS'(1);
          end
          if (rise2) begin
            quo_q    <= DIVIDEND_V;
            rem_q    <= '0;
            divCnt_q <= '0;
            state_q  <= DIVIDE;
          end
        end

        DIVIDE: begin
          if (divCnt_q != DIV_STEPS) begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            divCnt_q <= divCnt_q + 5'd1;
          end else begin
            if (ms_q == '0 || quo_q > SPEED_MAX_Q) begin
              speed_q <= SPEED_MAX;
            end else begin
              speed_q <= quo_q[WIDTH_SPEED-1:0];
            end
            frameIdx_q <= '0;
            bitIdx_q   <= '0;
            baudCnt_q  <= '0;
            txLine_q   <= 1'b0;
            state_q    <= SEND;
          end
        end

        // bitIdx 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
        SEND: begin
          if (baudCnt_q == BAUD_LAST) begin
            baudCnt_q <= '0;
            if (bitIdx_q == 4'd9) begin
              bitIdx_q <= '0;
              if (frameIdx_q == LAST_FRAME) begin
                txLine_q <= 1'b1;
                state_q  <= WAIT_EXIT;
              end else begin
                frameIdx_q <= frameIdx_q + 2'd1;
                txLine_q   <= 1'b0;
              end
            end else begin
              bitIdx_q <= bitIdx_q + 4'd1;
              txLine_q <= (bitIdx_q == 4'd8) ? 1'b1 : frameByte[bitIdx_q[2:0]];
            end
          end else begin
            baudCnt_q <= baudCnt_q + BAUD_W'(1);
          end
        end

        WAIT_EXIT: begin
          if (fall3 || (!s1 && !s2 && !s3)) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TOLL_OVERSPEED_EN
  // The speed is unknown while dividing, so a pass read then is held off until the result exists.
  assign epassSet = s2 && (pass == 2'b10) &&
                    !(state_q == DIVIDE ||
                      ((state_q == SEND || state_q == WAIT_EXIT) && overspeed));
`else
  assign epassSet = s2 && (pass == 2'b10);
`endif

  always_comb begin
    barrier_d = barrier_q;
    if (fall3 && !en) begin
      barrier_d = 1'b0;
    end
    if (en || epassSet) begin
      barrier_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      barrier_q <= 1'b0;
    end else begin
      barrier_q <= barrier_d;
    end
  end

  assign barrier         = barrier_q;
  assign serial_data_out = txLine_q;

endmodule

// File: tb/tb_toll_gate_top.sv
// Directed testbench for toll_gate_top: speed report frames, barrier control and reset behaviour.
// Scaled clocking: SYS_FREQ=10_000 and BAUD=1000 give 10 clk per ms and 10 clk per UART bit.
module tb_toll_gate_top;

  localparam int SYS_FREQ = 10_000;
  localparam int BAUD     = 1000;
  localparam int BIT      = SYS_FREQ / BAUD;
  localparam int MS       = SYS_FREQ / 1000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sensor1 = 1'b0;
  logic       sensor2 = 1'b0;
  logic       sensor3 = 1'b0;
  logic [1:0] valid_Epass = 2'b00;
  logic       enable = 1'b0;
  logic       barrier;
  logic       serial_data_out;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int         gapMs;
    logic [7:0] expHi;
    logic [7:0] expLo;
  } speedVec_t;

  speedVec_t vecs[6];

  toll_gate_top #(
    .SYS_FREQ(SYS_FREQ),
    .BAUD(BAUD),
    .WIDTH_MS(16),
    .WIDTH_SPEED(14)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sensor1(sensor1),
    .sensor2(sensor2),
    .sensor3(sensor3),
    .valid_Epass(valid_Epass),
    .enable(enable),
    .barrier(barrier),
    .serial_data_out(serial_data_out)
  );

  always #5 clk = ~clk;

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s1, input logic s2, input logic s3,
                               input logic [1:0] pass, input logic en);
    sensor1     = s1;
    sensor2     = s2;
    sensor3     = s3;
    valid_Epass = pass;
    enable      = en;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits up to budget cycles for a start bit, then samples each bit mid-period.
  task automatic rxByte(input int budget, output logic [7:0] data,
                        output logic seen, output logic stopOk);
    int waited = 0;
    data   = 8'h00;
    seen   = 1'b0;
    stopOk = 1'b0;
    while (serial_data_out !== 1'b0 && waited < budget) begin
      waitCycles(1);
      waited++;
    end
    if (serial_data_out === 1'b0) begin
      seen = 1'b1;
      waitCycles(BIT / 2);
      for (int i = 0; i < 8; i++) begin
        waitCycles(BIT);
        data[i] = serial_data_out;
      end
      waitCycles(BIT);
      stopOk = (serial_data_out === 1'b1);
    end
  endtask

  task automatic watchIdle(input int n, output logic allHigh);
    allHigh = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (serial_data_out !== 1'b1) allHigh = 1'b0;
      waitCycles(1);
    end
  endtask

  task automatic runSpeed(input int gapMs, input logic [7:0] expHi,
                          input logic [7:0] expLo, input string tag);
    logic [7:0] b;
    logic seen, stopOk, idle;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(gapMs * MS);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    rxByte(100, b, seen, stopOk);
    checkOutput($sformatf("%s hi frame seen", tag), 32'(seen), 32'd1);
    checkOutput($sformatf("%s hi byte", tag), 32'(b), 32'(expHi));
    checkOutput($sformatf("%s hi stop", tag), 32'(stopOk), 32'd1);
    rxByte(10, b, seen, stopOk);
    checkOutput($sformatf("%s lo frame back-to-back", tag), 32'(seen), 32'd1);
    checkOutput($sformatf("%s lo byte", tag), 32'(b), 32'(expLo));
    checkOutput($sformatf("%s lo stop", tag), 32'(stopOk), 32'd1);
    watchIdle(150, idle);
    checkOutput($sformatf("%s no third frame", tag), 32'(idle), 32'd1);
    checkOutput($sformatf("%s barrier closed", tag), 32'(barrier), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(10);
  endtask

  initial begin
    logic idle;

    // 144000 / gap, saturating at 16383 for short gaps.
    vecs[0] = '{gapMs: 640,  expHi: 8'h00, expLo: 8'hE1};
    vecs[1] = '{gapMs: 480,  expHi: 8'h01, expLo: 8'h2C};
    vecs[2] = '{gapMs: 240,  expHi: 8'h02, expLo: 8'h58};
    vecs[3] = '{gapMs: 1000, expHi: 8'h00, expLo: 8'h90};
    vecs[4] = '{gapMs: 9,    expHi: 8'h3E, expLo: 8'h80};
    vecs[5] = '{gapMs: 8,    expHi: 8'h3F, expLo: 8'hFF};

    reset_n = 1'b1;
    waitCycles(2);
    checkOutput("reset barrier", 32'(barrier), 32'd0);
    checkOutput("reset line", 32'(serial_data_out), 32'd1);
    reset_n = 1'b0;
    watchIdle(100, idle);
    checkOutput("idle after reset", 32'(idle), 32'd1);

    for (int i = 0; i < 6; i++) begin
      runSpeed(vecs[i].gapMs, vecs[i].expHi, vecs[i].expLo, $sformatf("vec%0d", i));
    end

    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    waitCycles(3);
    checkOutput("epass raise in 3 clk", 32'(barrier), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    waitCycles(5);
    checkOutput("epass held while s3 high", 32'(barrier), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(5);
    checkOutput("epass clear on s3 fall", 32'(barrier), 32'd0);

    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    waitCycles(6);
    checkOutput("invalid pass no raise", 32'(barrier), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    waitCycles(6);
    checkOutput("pass 11 no raise", 32'(barrier), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    waitCycles(4);
    checkOutput("enable raise", 32'(barrier), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    waitCycles(5);
    checkOutput("enable holds over s3 fall", 32'(barrier), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(5);
    checkOutput("enable drop keeps barrier", 32'(barrier), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(5);
    checkOutput("clear after enable drop", 32'(barrier), 32'd0);

    // One-cycle pass pulse lands on the same cycle as the sensor3 fall.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    waitCycles(5);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(5);
    checkOutput("set wins over clear", 32'(barrier), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(5);
    checkOutput("cleanup clear", 32'(barrier), 32'd0);

    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    waitCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(300 * MS);
    checkOutput("barrier up before reset", 32'(barrier), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    reset_n = 1'b1;
    waitCycles(2);
    checkOutput("mid reset barrier", 32'(barrier), 32'd0);
    checkOutput("mid reset line", 32'(serial_data_out), 32'd1);
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    watchIdle(400, idle);
    checkOutput("no frame after reset", 32'(idle), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    waitCycles(10);
    runSpeed(640, 8'h00, 8'hE1, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
